// File: rtl/program_memory.sv
// rtl/program_memory.sv - word-organised program memory with fetch, rw and loader ports
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   fetch_addr/stall    fetch byte address and hold request
//   fetch_data          registered fetch word (FILL_WORD while busy)
//   rw_addr/we/be/wdata data-port byte address, write enable, byte enables, write data
//   rw_rdata            registered read data (holds during writes)
//   load_start/base     begin a streamed load at a byte address
//   load_valid/data/last, load_ready   loader word stream handshake
//   busy                clear sweep or load in progress
//   misaligned_err      one-cycle pulse after a misaligned rw write
module program_memory #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          DEPTH          = 4096,
  parameter int          ADDR_WIDTH     = $clog2(DEPTH) + 2,
  parameter logic [31:0] FILL_WORD      = 32'h00000013,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   fetch_addr,
  input  logic                    fetch_stall,
  output logic [DATA_WIDTH-1:0]   fetch_data,
  input  logic [ADDR_WIDTH-1:0]   rw_addr,
  input  logic                    rw_we,
  input  logic [DATA_WIDTH/8-1:0] rw_be,
  input  logic [DATA_WIDTH-1:0]   rw_wdata,
  output logic [DATA_WIDTH-1:0]   rw_rdata,
  input  logic                    load_start,
  input  logic [ADDR_WIDTH-1:0]   load_base,
  input  logic                    load_valid,
  input  logic [DATA_WIDTH-1:0]   load_data,
  input  logic                    load_last,
  output logic                    load_ready,
  output logic                    busy,
  output logic                    misaligned_err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [DATA_WIDTH-1:0] FILL = DATA_WIDTH'(FILL_WORD);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD
  } state_t;

  state_t state, state_next;
  logic [IDX_W-1:0] ptr, ptr_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  mem_we;
  logic [IDX_W-1:0]      mem_widx;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_wbe;

  logic [IDX_W-1:0] fetch_idx, rw_idx;
  logic             rw_aligned;

  // The two byte-offset bits of fetch and load addresses are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{fetch_addr[1:0], load_base[1:0]};

  assign fetch_idx  = fetch_addr[ADDR_WIDTH-1:2];
  assign rw_idx     = rw_addr[ADDR_WIDTH-1:2];
  assign rw_aligned = (rw_addr[1:0] == 2'b00);

  // busy and load_ready are pure decodes of the state register, so they
  // change exactly one cycle after the transition that causes them.
  assign busy       = (state != ST_IDLE);
  assign load_ready = (state == ST_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Only one writer can own the array in any state: the sweep in CLEAR,
  // the loader in LOAD, and the rw port only when idle.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    mem_we     = 1'b0;
    mem_widx   = ptr;
    mem_wdata  = load_data;
    mem_wbe    = '1;
    case (state)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_wdata = FILL;
        ptr_next  = ptr + 1'b1;
        if (ptr == IDX_W'(DEPTH - 1)) begin
          state_next = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          mem_we   = 1'b1;
          ptr_next = ptr + 1'b1;
          if (load_last) begin
            state_next = ST_IDLE;
          end
        end
      end
      default: begin
        if (load_start) begin
          state_next = ST_LOAD;
          ptr_next   = load_base[ADDR_WIDTH-1:2];
        end
        if (rw_we && rw_aligned) begin
          mem_we    = 1'b1;
          mem_widx  = rw_idx;
          mem_wdata = rw_wdata;
          mem_wbe   = rw_be;
        end
      end
    endcase
  end

  // Reset aborts any write in flight; contents are otherwise untouched.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_wbe[b]) begin
          mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  // Reads sample the array before this edge's write lands (read-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_data     <= FILL;
      rw_rdata       <= '0;
      misaligned_err <= 1'b0;
    end else begin
      if (!fetch_stall) begin
        fetch_data <= busy ? FILL : mem[fetch_idx];
      end
      if (!rw_we) begin
        rw_rdata <= mem[rw_idx];
      end
      misaligned_err <= rw_we && !rw_aligned;
    end
  end

endmodule

// File: tb/tb_program_memory.sv
// tb/tb_program_memory.sv - randomized directed bench for program_memory against an array model
module tb_program_memory;

  localparam int          DW    = 32;
  localparam int          DEPTH = 16;
  localparam int          AW    = 6;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] fetch_addr;
  logic          fetch_stall;
  logic [DW-1:0] fetch_data;
  logic [AW-1:0] rw_addr;
  logic          rw_we;
  logic [3:0]    rw_be;
  logic [DW-1:0] rw_wdata;
  logic [DW-1:0] rw_rdata;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          busy;
  logic          misaligned_err;

  always #5 clk = ~clk;

  program_memory #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .ADDR_WIDTH(AW),
    .FILL_WORD(NOP),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fetch_addr(fetch_addr),
    .fetch_stall(fetch_stall),
    .fetch_data(fetch_data),
    .rw_addr(rw_addr),
    .rw_we(rw_we),
    .rw_be(rw_be),
    .rw_wdata(rw_wdata),
    .rw_rdata(rw_rdata),
    .load_start(load_start),
    .load_base(load_base),
    .load_valid(load_valid),
    .load_data(load_data),
    .load_last(load_last),
    .load_ready(load_ready),
    .busy(busy),
    .misaligned_err(misaligned_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] model [DEPTH];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    logic [31:0] m;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        m = 32'hFF << (8 * b);
        r = (r & ~m) | (wd & m);
      end
    end
    return r;
  endfunction

  task automatic rw_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] be);
    rw_addr  = addr;
    rw_wdata = data;
    rw_be    = be;
    rw_we    = 1'b1;
    step();
    rw_we = 1'b0;
    model[addr[AW-1:2]] = merge(model[addr[AW-1:2]], data, be);
  endtask

  task automatic rw_read(input int word, input string tag);
    rw_addr = AW'(word * 4);
    rw_we   = 1'b0;
    step();
    check(tag, rw_rdata, model[word]);
  endtask

  task automatic load_image(input logic [AW-1:0] base, input int n, input bit fixed);
    logic [31:0] d;
    int          w;
    load_start = 1'b1;
    load_base  = base;
    step();
    load_start = 1'b0;
    check("load_ready_after_start", 32'(load_ready), 32'd1);
    check("busy_during_load", 32'(busy), 32'd1);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) begin
        load_valid = 1'b0;
        step();
      end
      d = fixed ? (32'hA0 + 32'(k)) : $urandom;
      load_valid = 1'b1;
      load_data  = d;
      load_last  = (k == n - 1);
      step();
      w = (int'(base[AW-1:2]) + k) % DEPTH;
      model[w] = d;
      load_valid = 1'b0;
      load_last  = 1'b0;
    end
    check("load_ready_drop", 32'(load_ready), 32'd0);
    check("busy_drop_after_load", 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          cnt;
    logic [31:0] old_w;
    logic [31:0] new_w;
    logic [31:0] prev_rd;

    rst = 1'b1;
    fetch_addr = '0; fetch_stall = 1'b0;
    rw_addr = '0; rw_we = 1'b0; rw_be = '0; rw_wdata = '0;
    load_start = 1'b0; load_base = '0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    step();
    step();
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_load_ready", 32'(load_ready), 32'd0);
    check("reset_fetch_data", fetch_data, NOP);
    check("reset_rw_rdata", rw_rdata, 32'd0);
    check("reset_misaligned", 32'(misaligned_err), 32'd0);

    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      cnt++;
      step();
    end
    check("clear_busy_cycles", 32'(cnt), 32'd16);
    for (int i = 0; i < DEPTH; i++) model[i] = NOP;

    for (int i = 0; i < DEPTH; i++) begin
      fetch_addr = {4'(i), 2'($urandom)};
      step();
      check("fetch_after_clear", fetch_data, model[i]);
    end

    load_valid = 1'b1; load_data = $urandom; load_last = 1'b1;
    step();
    check("idle_load_ready_low", 32'(load_ready), 32'd0);
    load_valid = 1'b0; load_last = 1'b0;

    load_image(6'h38, 4, 1'b1);
    rw_read(14, "load_wrap_w14");
    rw_read(15, "load_wrap_w15");
    rw_read(0, "load_wrap_w0");
    rw_read(1, "load_wrap_w1");
    check("load_wrap_w1_const", rw_rdata, 32'h000000A3);

    load_image($urandom, $urandom_range(1, 5), 1'b0);
    for (int i = 0; i < DEPTH; i++) rw_read(i, "read_after_rand_load");

    rw_read(2, "pre_be_read");
    prev_rd = rw_rdata;
    rw_write(6'h08, 32'hDEADBEEF, 4'b1111);
    check("rdata_holds_on_write", rw_rdata, prev_rd);
    check("aligned_no_err", 32'(misaligned_err), 32'd0);
    rw_write(6'h08, 32'h00001200, 4'b0010);
    rw_read(2, "be_merge_model");
    check("be_merge_const", rw_rdata, 32'hDEAD12EF);

    for (int i = 0; i < 24; i++) begin
      rw_write(AW'($urandom_range(0, DEPTH - 1) * 4), $urandom, 4'($urandom));
      rw_read($urandom_range(0, DEPTH - 1), "rand_rw_read");
    end

    fetch_addr = 6'h14;
    step();
    old_w = model[5];
    new_w = $urandom;
    rw_write(6'h14, new_w, 4'hF);
    check("fetch_read_first", fetch_data, old_w);
    step();
    check("fetch_after_rw_write", fetch_data, new_w);

    load_start = 1'b1; load_base = 6'h1C;
    step();
    load_start = 1'b0;
    old_w = model[7];
    new_w = $urandom;
    load_valid = 1'b1; load_data = new_w; load_last = 1'b1;
    rw_addr = 6'h1C; rw_we = 1'b0;
    step();
    load_valid = 1'b0; load_last = 1'b0;
    model[7] = new_w;
    check("rw_read_first_vs_loader", rw_rdata, old_w);
    step();
    check("rw_read_after_loader", rw_rdata, new_w);

    fetch_addr = 6'h08;
    step();
    check("fetch_w2_before_stall", fetch_data, model[2]);
    old_w = model[2];
    fetch_stall = 1'b1;
    new_w = $urandom;
    rw_write(6'h08, new_w, 4'hF);
    check("fetch_stall_hold_1", fetch_data, old_w);
    step();
    check("fetch_stall_hold_2", fetch_data, old_w);
    fetch_stall = 1'b0;
    step();
    check("fetch_stall_release", fetch_data, new_w);

    rw_addr = 6'h0A; rw_wdata = ~model[2]; rw_be = 4'hF; rw_we = 1'b1;
    step();
    check("misaligned_pulse", 32'(misaligned_err), 32'd1);
    rw_we = 1'b0; rw_addr = 6'h08;
    step();
    check("misaligned_one_cycle", 32'(misaligned_err), 32'd0);
    check("misaligned_no_write", rw_rdata, model[2]);

    load_start = 1'b1; load_base = 6'h10;
    step();
    load_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      load_valid = 1'b1; load_data = $urandom ^ NOP; load_last = 1'b0;
      step();
      model[4 + k] = load_data;
    end
    load_valid = 1'b0;
    rst = 1'b1;
    step();
    check("mid_load_reset_ready", 32'(load_ready), 32'd0);
    check("mid_load_reset_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    fetch_addr = 6'h14;
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      cnt++;
      rw_we = (k == 10); rw_addr = 6'h00; rw_wdata = 32'hCAFEF00D; rw_be = 4'hF;
      step();
      if (k == 0) check("fetch_nop_while_busy", fetch_data, NOP);
    end
    rw_we = 1'b0;
    check("reclear_busy_cycles", 32'(cnt), 32'd16);
    for (int i = 0; i < DEPTH; i++) model[i] = NOP;
    for (int i = 0; i < DEPTH; i++) rw_read(i, "read_after_reclear");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/program_memory.md
Name: program_memory

Overview:
- Word-organised instruction/program memory for the RV32E core, parametrised in data width and depth.
- Read-only fetch port with stall-hold feeds the IF stage.
- Read/write data port with byte enables serves debug and self-modifying access.
- Adds a reset-time clear sweep and a valid/ready program-loader stream, so images can be loaded at runtime without a memory file.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8.
DEPTH, 4096, number of words; power of two, at least 4.
ADDR_WIDTH, $clog2(DEPTH)+2, byte-address width.
FILL_WORD, 32'h00000013, clear value (RV NOP, addi x0,x0,0); truncated or zero-extended to DATA_WIDTH.
CLEAR_ON_RESET, 1, 1 = sweep FILL_WORD into every word after reset; 0 = no sweep.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
fetch_addr  in  ADDR_WIDTH  fetch byte address.
fetch_stall  in  1  1 = hold fetch_data.
fetch_data  out  DATA_WIDTH  registered fetch word.
rw_addr  in  ADDR_WIDTH  data-port byte address.
rw_we  in  1  write enable.
rw_be  in  DATA_WIDTH/8  byte enables; bit i selects byte i.
rw_wdata  in  DATA_WIDTH  write data.
rw_rdata  out  DATA_WIDTH  registered read data.
load_start  in  1  pulse: begin a load at load_base.
load_base  in  ADDR_WIDTH  load start byte address.
load_valid  in  1  loader word valid.
load_data  in  DATA_WIDTH  loader word.
load_last  in  1  final word of the image.
load_ready  out  1  loader accepts a word.
busy  out  1  CLEAR or LOAD in progress.
misaligned_err  out  1  one-cycle pulse on a misaligned rw access.

Behaviour:
- Word index is addr[ADDR_WIDTH-1:2]; addr[1:0] is dropped for fetch.
- Reset (sync, rst=1):
  - state <= CLEAR if CLEAR_ON_RESET, else IDLE; ptr <= 0.
  - fetch_data <= FILL_WORD; rw_rdata <= 0; load_ready <= 0; misaligned_err <= 0.
  - busy <= CLEAR_ON_RESET.
  - Reset mid-CLEAR or mid-LOAD aborts immediately; memory contents are left as-is, then the sweep restarts if enabled.
- CLEAR:
  - Writes FILL_WORD at ptr each cycle; ptr increments.
  - After the write at ptr = DEPTH-1: state goes IDLE and busy drops. busy is high for exactly DEPTH cycles after rst deasserts.
- IDLE:
  - load_start=1: latch ptr <= load_base word index, go LOAD, load_ready <= 1 and busy <= 1 next cycle.
  - load_start in CLEAR or LOAD is ignored.
- LOAD:
  - Each cycle with load_valid and load_ready: mem[ptr] <= load_data, ptr <= ptr+1 (wraps modulo DEPTH).
  - Handshake with load_last=1: go IDLE; load_ready and busy drop the next cycle.
  - load_valid with load_ready low is not consumed.
- Fetch port, 1-cycle latency:
  - !fetch_stall: fetch_data <= mem[idx].
  - fetch_stall: fetch_data holds.
  - While busy and !fetch_stall: fetch_data <= FILL_WORD, so a non-stalled core executes NOPs.
- RW port, 1-cycle latency:
  - rw_we=0: rw_rdata <= mem[idx].
  - rw_we=1 and addr[1:0]==0 and !busy: write bytes where rw_be[i]=1; rw_rdata holds.
  - rw_we=1 with addr[1:0]!=0: write suppressed; misaligned_err=1 on the next cycle only.
  - rw_we=1 while busy: write dropped silently.
  - Reads while busy return mem contents as usual.
- Simultaneous access to the same word (rw write with fetch, or loader write with rw read): read-first; the reader gets the old word.
- Address range: upper address bits beyond ADDR_WIDTH do not exist; indices wrap naturally.

Test Plan:
- DEPTH=16, CLEAR_ON_RESET=1: assert rst 2 cycles, release -> busy high exactly 16 cycles; then each fetch of 0x00..0x3C returns 0x00000013.
- load_start with load_base=0x38, stream 0xA0,0xA1,0xA2,0xA3 (last on 4th) -> words 14,15,0,1 hold A0,A1,A2,A3 (wrap); load_ready and busy drop the cycle after the last handshake.
- rw write 0xDEADBEEF to 0x08 with rw_be=4'b1111, then rw_be=4'b0010 with 0x00001200 -> rw_read 0x08 returns 0xDEAD12EF.
- fetch_addr=0x08 with fetch_stall=1 while rw overwrites word 2 -> fetch_data unchanged; stall released -> new value appears 1 cycle later.
- rw_we=1 at 0x0A -> no write; misaligned_err pulses exactly 1 cycle; a write issued during CLEAR is absent after the sweep.
- rst asserted mid-LOAD after 2 words -> load_ready=0 and a fresh CLEAR runs; after 16 cycles every word reads 0x00000013.
